// File: rtl/sram_b_pkg.sv
// sram_b_pkg: shared state type and sizing constants for the SRAM port-1 stream reader.
package sram_b_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_e;
  localparam int RD_FIFO_DEPTH = 3;
  localparam int RD_CREDITS    = 3;
endpackage

// File: rtl/sram_b_rd_fifo.sv
// sram_b_rd_fifo: small register FIFO that holds SRAM read words until the consumer takes them.
module sram_b_rd_fifo import sram_b_pkg::*; #(
  parameter int DBITS = 8,
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1),
  localparam int PW = $clog2(RD_FIFO_DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [DBITS-1:0] push_data,
  input  logic             pop,
  output logic [DBITS-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [DBITS-1:0] mem_q [RD_FIFO_DEPTH];
  logic [DBITS-1:0] mem_d [RD_FIFO_DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RD_FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok = pop && count_q != '0;
  assign head   = mem_q[rd_q];
  assign count  = count_q;
  assign empty  = count_q == '0;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d    = push ? nxt(wr_q) : wr_q;
    rd_d    = pop_ok ? nxt(rd_q) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop_ok);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/sram_b_stream_reader.sv
// sram_b_stream_reader: turns (base, length) commands into SRAM port-1 reads and a
// backpressured valid/ready word stream, hiding the one-cycle Q1 latency behind a credit FIFO.
module sram_b_stream_reader import sram_b_pkg::*; #(
  parameter int ABITS = 7,
  parameter int DBITS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ABITS-1:0] cmd_base,
  input  logic [ABITS:0]   cmd_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1
);
  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  rd_state_e        state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [ABITS:0]   issue_left_q, issue_left_d, out_left_q, out_left_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      outstanding;
  logic             fifo_empty, issue, pop;

  sram_b_rd_fifo #(.DBITS(DBITS)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (inflight_q),
    .push_data (Q1),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Words already requested but not yet consumed must fit in the FIFO.
  assign outstanding = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign issue       = state_q == READ && issue_left_q != '0 && outstanding < (CW+1)'(RD_CREDITS);
  assign CE1         = issue;
  assign A1          = addr_q;
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign out_valid   = !fifo_empty;
  assign out_last    = out_valid && out_left_q == (ABITS+1)'(1);
  assign pop         = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = issue;
    if (state_q == IDLE && cmd_valid) begin
      addr_d       = cmd_base;
      issue_left_d = cmd_len;
      out_left_d   = cmd_len;
      state_d      = cmd_len == '0 ? IDLE : READ;
    end
    if (issue) begin
      addr_d       = addr_q + 1'b1;
      issue_left_d = issue_left_q - 1'b1;
      state_d      = issue_left_q == (ABITS+1)'(1) ? DRAIN : state_d;
    end
    if (pop) begin
      out_left_d = out_left_q - 1'b1;
      state_d    = out_left_q == (ABITS+1)'(1) ? IDLE : state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
    end
  end
endmodule

// File: tb/tb_sram_b_stream_reader.sv
// tb_sram_b_stream_reader: directed checks of the stream reader against a behavioural 1-cycle SRAM.
module tb_sram_b_stream_reader;
  logic       CLK = 0, RST_N = 0;
  logic       cmd_valid = 0, cmd_ready;
  logic [6:0] cmd_base = '0;
  logic [7:0] cmd_len = '0;
  logic       out_valid, out_ready = 0, out_last, busy, CE1;
  logic [7:0] out_data, Q1, q1 = '0;
  logic [6:0] A1;
  logic [7:0] mem [128];
  int total = 0, bad = 0;

  sram_b_stream_reader #(.ABITS(7), .DBITS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (CE1) q1 <= mem[A1];
  assign Q1 = q1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_ce1"}, 32'(CE1), 0);
  endtask

  // mode 0: out_ready always high with exact beat timing; mode 1: stalls plus random ready.
  task automatic run_cmd(input logic [6:0] base, input logic [7:0] len, input int mode, input int stop);
    int t = 0, issued = 0, popped = 0;
    bit done = 0;
    logic [6:0] ea, da;
    cmd_valid = 1; cmd_base = base; cmd_len = len;
    chk("accept_ready", 32'(cmd_ready), 1);
    @(negedge CLK);
    cmd_valid = (mode == 1);
    cmd_base = 7'h55; cmd_len = 8'd1;
    chk("busy_after_accept", 32'(busy), 1);
    chk("no_ready_busy", 32'(cmd_ready), 0);
    while (!done && t < 2000) begin
      out_ready = (mode == 0) ? 1'b1 :
                  ((t >= 4 && t < 14) || (t >= 30 && t < 40)) ? 1'b0 : 1'($urandom_range(0, 1));
      if (CE1) begin
        ea = base + issued[6:0];
        chk("credit", 32'(issued - popped <= 2), 1);
        chk("a1", 32'(A1), 32'(ea));
        issued++;
      end
      if (out_valid) chk("last_flag", 32'(out_last), 32'(popped == int'(len) - 1));
      if (out_valid && out_ready) begin
        da = base + popped[6:0];
        chk("data", 32'(out_data), 32'(mem[da]));
        if (mode == 0) chk("beat_time", t, 2 + popped);
        popped++;
      end
      if (popped == stop) begin
        done = 1;
        cmd_valid = 0;
      end
      @(negedge CLK);
      t++;
    end
    if (!done) chk("timeout", 0, 1);
    out_ready = 0;
    if (stop == int'(len)) begin
      chk("issued_count", issued, int'(len));
      check_idle_outputs("post_cmd");
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    @(negedge CLK);
    check_idle_outputs("reset");
    chk("reset_a1", 32'(A1), 0);
    chk("reset_data", 32'(out_data), 0);
    RST_N = 1;
    @(negedge CLK);

    run_cmd(7'h10, 8'd4, 0, 4);
    run_cmd(7'h7E, 8'd4, 0, 4);
    run_cmd(7'h00, 8'd16, 1, 16);

    cmd_valid = 1; cmd_base = 7'h33; cmd_len = 8'd0;
    @(negedge CLK);
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check_idle_outputs("len0");
      @(negedge CLK);
    end

    run_cmd(7'h40, 8'd128, 0, 128);

    run_cmd(7'h20, 8'd8, 0, 3);
    #2 RST_N = 0;
    #1;
    check_idle_outputs("mid_reset");
    chk("mid_reset_a1", 32'(A1), 0);
    chk("mid_reset_data", 32'(out_data), 0);
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    run_cmd(7'h50, 8'd3, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
